// File: rtl/pulse_gen_pkg.sv
// Shared types and default parameters for the pulse_gen block.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_NUM_W = 8;

endpackage

// File: rtl/pulse_gen_cnt.sv
// Phase counter for pulse_gen: counts 0..limit-1 while enabled and flags the wrap cycle.
module pulse_gen_cnt
  import pulse_gen_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  // wrap is the last phase of a period; only meaningful while counting
  assign wrap = en && (count == limit - W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// Multi-channel periodic pulse generator with finite or free-running trains.
// Optional PULSE_GEN_TRACE_EN adds a simulation-only trace of every output change.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_cnt
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] h_q;
  logic [NUM_W-1:0] n_q;
  logic [NCH-1:0]   en_q;

  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_nxt;
  logic [CNT_W-1:0] h_sel;
  logic [NCH-1:0]   mask_sel;
  logic [NCH-1:0]   out_nxt;

  logic load;
  logic cnt_clr;
  logic cnt_en;
  logic wrap;
  logic accept;
  logic last;

  assign accept = start && !abort && (period != '0);
  assign last   = wrap && (n_q != '0) && (pulse_cnt == n_q - NUM_W'(1));

  pulse_gen_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .limit(p_q),
    .count(phase),
    .wrap (wrap)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          load      = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output is registered from the phase the counter will hold next cycle
  always_comb begin
    phase_nxt = phase;
    if (cnt_clr) begin
      phase_nxt = '0;
    end else if (cnt_en) begin
      phase_nxt = wrap ? '0 : phase + CNT_W'(1);
    end
    mask_sel = load ? ch_en : en_q;
    h_sel    = load ? high_len : h_q;
    out_nxt  = '0;
    if (state_nxt == RUN) begin
      out_nxt = mask_sel & {NCH{phase_nxt < h_sel}};
    end
  end

  // Train configuration, outputs and completed-period counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q       <= '0;
      h_q       <= '0;
      n_q       <= '0;
      en_q      <= '0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      if (load) begin
        p_q  <= period;
        h_q  <= high_len;
        n_q  <= num_pulses;
        en_q <= ch_en;
      end
      out  <= out_nxt;
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (load) begin
        pulse_cnt <= '0;
      end else if (wrap) begin
        pulse_cnt <= pulse_cnt + NUM_W'(1);
      end
    end
  end

`ifdef PULSE_GEN_TRACE_EN
  always @(out) begin
    $display("%0t pulse_gen state=%s phase=%0d out=%b", $time, state.name(), phase, out);
  end
`endif

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: directed scenarios plus random stimulus vs. a train-level model.
module tb_pulse_gen;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NUM_W = 8;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_len;
  logic [NUM_W-1:0] num_pulses;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   out;
  logic             busy;
  logic             done;
  logic [NUM_W-1:0] pulse_cnt;

  int n_err = 0;
  int n_chk = 0;

  // Model: a train is described by its elapsed cycle count t and its latched settings
  int m_mode = M_IDLE;
  int m_t    = 0;
  int m_p    = 1;
  int m_h    = 0;
  int m_n    = 0;
  int m_mask = 0;
  int m_cnt  = 0;

  pulse_gen #(
    .NCH  (NCH),
    .CNT_W(CNT_W),
    .NUM_W(NUM_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .period    (period),
    .high_len  (high_len),
    .num_pulses(num_pulses),
    .ch_en     (ch_en),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_t    = 0;
      m_cnt  = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start && !abort && period != 0) begin
            m_mode = M_RUN;
            m_t    = 0;
            m_p    = int'(period);
            m_h    = int'(high_len);
            m_n    = int'(num_pulses);
            m_mask = int'(ch_en);
          end
        end
        M_RUN: begin
          if (abort) begin
            m_mode = M_IDLE;
            m_cnt  = (m_t / m_p) % 256;
          end else begin
            m_t++;
            if (m_n != 0 && m_t == m_n * m_p) begin
              m_mode = M_DONE;
              m_cnt  = m_n;
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // One clock: model follows the sampled inputs, outputs checked 1 time unit after the edge
  task automatic cycle();
    int exp_out;
    int exp_cnt;
    @(posedge clk);
    model_step();
    #1;
    exp_out = 0;
    exp_cnt = m_cnt;
    if (m_mode == M_RUN) begin
      if ((m_t % m_p) < m_h) exp_out = m_mask;
      exp_cnt = (m_t / m_p) % 256;
    end
    check("out", 32'(out), 32'(exp_out));
    check("busy", 32'(busy), 32'(m_mode == M_RUN));
    check("done", 32'(done), 32'(m_mode == M_DONE));
    check("pulse_cnt", 32'(pulse_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    period = '0; high_len = '0; num_pulses = '0; ch_en = '0;
    cycle();
    cycle();
    check("rst_out", 32'(out), 32'd0);
    check("rst_cnt", 32'(pulse_cnt), 32'd0);
    rst_n = 1'b1;
    cycle();

    // P=4 H=1 N=3, inputs changed after start must not matter
    period = 8'd4; high_len = 8'd1; num_pulses = 8'd3; ch_en = 4'b0101; start = 1'b1;
    cycle();
    check("t1_first_out", 32'(out), 32'h5);
    start = 1'b0; period = 8'd7; high_len = 8'd0; num_pulses = 8'd1; ch_en = 4'b1010;
    repeat (12) cycle();
    check("t1_done", 32'(done), 32'd1);
    check("t1_cnt", 32'(pulse_cnt), 32'd3);
    cycle();
    check("t1_hold_cnt", 32'(pulse_cnt), 32'd3);

    // H >= P keeps enabled channels high
    period = 8'd3; high_len = 8'd5; num_pulses = 8'd2; ch_en = 4'b1111; start = 1'b1;
    cycle();
    start = 1'b0;
    check("t2_out", 32'(out), 32'hf);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t2_out", 32'(out), 32'hf);
    end
    cycle();
    check("t2_done", 32'(done), 32'd1);
    cycle();

    // Free-run aborted at cycle 5
    period = 8'd4; high_len = 8'd2; num_pulses = 8'd0; ch_en = 4'b0011; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_out", 32'(out), 32'd0);
    check("t3_cnt", 32'(pulse_cnt), 32'd1);
    repeat (3) cycle();

    // Reset mid-train, then a normal train
    period = 8'd3; high_len = 8'd1; num_pulses = 8'd5; ch_en = 4'b1001; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_cnt", 32'(pulse_cnt), 32'd0);
    period = 8'd2; high_len = 8'd1; num_pulses = 8'd2; ch_en = 4'b0110; start = 1'b1;
    cycle();
    start = 1'b0;
    check("t4_restart_out", 32'(out), 32'h6);
    repeat (4) cycle();
    check("t4_done", 32'(done), 32'd1);
    cycle();

    // Illegal starts in IDLE
    period = 8'd0; high_len = 8'd1; num_pulses = 8'd1; start = 1'b1;
    cycle();
    check("t5_zero_period", 32'(busy), 32'd0);
    period = 8'd3; abort = 1'b1;
    cycle();
    check("t5_start_abort", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0;
    cycle();

    // Long free-run: pulse_cnt wraps past 255
    period = 8'd2; high_len = 8'd1; num_pulses = 8'd0; ch_en = 4'b1111; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (510) cycle();
    check("t6_cnt_255", 32'(pulse_cnt), 32'd255);
    repeat (2) cycle();
    check("t6_cnt_wrap", 32'(pulse_cnt), 32'd0);
    check("t6_no_done", 32'(done), 32'd0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;

    // Random traffic, including starts during RUN/DONE and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      period     = 8'($urandom_range(0, 6));
      high_len   = 8'($urandom_range(0, 8));
      num_pulses = 8'($urandom_range(0, 4));
      ch_en      = 4'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clock port clk, reset port rst_n.
REQ-002 Parameter NCH, default 4, SHALL set the number of output channels (1..16).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the period and high-length counters.
REQ-004 Parameter NUM_W, default 8, SHALL set the width of the pulse-count limit and counter.
REQ-005 Ports SHALL be, in this order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  request to begin a pulse train.
- abort  in  1  request to stop the train immediately.
- period  in  CNT_W  period length P in cycles; 0 is illegal.
- high_len  in  CNT_W  high cycles H per period.
- num_pulses  in  NUM_W  number of periods N; 0 means free-run.
- ch_en  in  NCH  per-channel enable mask.
- out  out  NCH  registered pulse outputs.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion strobe.
- pulse_cnt  out  NUM_W  completed periods.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-007 In IDLE, start=1 with period!=0 and abort=0 SHALL latch P, H, N and ch_en, clear pulse_cnt, and enter RUN with phase=0 on the next cycle.
REQ-008 In IDLE, start with period==0, or start together with abort, SHALL be ignored; the block stays in IDLE and abort wins.
REQ-009 In RUN, phase SHALL increment by 1 each cycle and wrap from P-1 to 0.
- At each wrap, pulse_cnt SHALL increment modulo 2^NUM_W.
REQ-010 The out register SHALL equal ch_en_q & {NCH{phase<H_q}} for the phase held in the same cycle; out SHALL be 0 in IDLE and DONE.
REQ-011 Edge cases for H:
- H==0 SHALL hold out constantly low for the whole train.
- H>=P SHALL hold enabled channels constantly high for the whole train.
REQ-012 With N!=0, the cycle where phase==P-1 and pulse_cnt==N-1 SHALL be the last RUN cycle; the next state SHALL be DONE.
REQ-013 DONE SHALL last exactly one cycle with done=1, busy=0 and pulse_cnt==N, then return to IDLE.
REQ-014 With N==0, RUN SHALL continue until abort; pulse_cnt wraps and done is never asserted.
REQ-015 In RUN, abort=1 SHALL force IDLE on the next cycle with out=0 and busy=0, without asserting done; pulse_cnt holds its value.
REQ-016 start received during RUN or DONE SHALL be ignored.
REQ-017 Inputs period, high_len, num_pulses and ch_en SHALL be sampled only at an accepted start; later changes SHALL NOT affect a running train.
REQ-018 pulse_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-019 On a clock edge with rst_n=0 the block SHALL enter IDLE with out=0, busy=0, done=0, pulse_cnt=0, phase=0 and all latched registers 0.
- This SHALL apply in any state, including mid-train.

Configuration
REQ-020 With macro PULSE_GEN_TRACE_EN defined, the block SHALL issue a simulation-only $display on every change of out, giving $time, state, phase and out in binary.
REQ-021 Without PULSE_GEN_TRACE_EN, no display code SHALL be compiled; synthesised logic SHALL be identical in both cases.

Structure
REQ-022 Shared package pulse_gen_pkg SHALL hold:
- the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
- default parameter constants.
REQ-023 The phase wrap counter SHALL be a sub-module pulse_gen_cnt with ports:
- clk, rst_n, clr, en, limit;
- outputs count and wrap.

Verification
REQ-024 P=4, H=1, N=3, ch_en=4'b0101, start at cycle 0 -> out=4'b0101 in cycles 1, 5 and 9, otherwise 0; busy in cycles 1-12; done in cycle 13 only; pulse_cnt=3.
REQ-025 P=3, H=5, N=2, ch_en=4'b1111 -> out=4'b1111 in cycles 1-6; done in cycle 7.
REQ-026 P=4, H=2, N=0, abort at cycle 5 -> out=0 and busy=0 from cycle 6; done never asserted; pulse_cnt=1.
REQ-027 rst_n=0 for one edge at cycle 4 of a running train -> all outputs 0 at the next cycle; a new start is accepted normally afterwards.
REQ-028 Two illegal starts: start with period=0, then start together with abort in IDLE -> both ignored; busy stays 0.
REQ-029 P=2, H=1, N=0 run for 513 cycles -> pulse_cnt wraps 255->0 and done stays 0.
